// File: rtl/load_store_unit.sv
// load_store_unit: data-side memory access stage; issues req/gnt/rvalid accesses and returns extended load data.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dMemRead,
  input  logic        dMemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] loadData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] addr_q, addr_d, sd_q, sd_d, ld_q, ld_d;
  logic [2:0] f3_q, f3_d;
  logic we_q, we_d, err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ill_f3, mis, legal, tmo;
  logic [31:0] sh, ext, wdata;
  logic [3:0] be;
  assign ill_f3 = dMemWrite ? (funct3[2] | &funct3[1:0]) : (&funct3[1:0] | funct3 == 3'b110);
  assign mis = funct3[1] ? |addr[1:0] : funct3[0] & addr[0];
  assign legal = (dMemRead ^ dMemWrite) & ~ill_f3 & ~mis;
  assign tmo = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  // Shift the addressed byte lane down to bit 0, then extend per size/sign.
  assign sh = mem_rdata >> {addr_q[1:0], 3'b000};
  assign ext = f3_q[1] ? sh :
               f3_q[0] ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} :
                         {{24{~f3_q[2] & sh[7]}}, sh[7:0]};
  assign be = f3_q[1] ? 4'hF : f3_q[0] ? 4'b0011 << {addr_q[1], 1'b0} : 4'b0001 << addr_q[1:0];
  assign wdata = f3_q[1] ? sd_q : f3_q[0] ? {2{sd_q[15:0]}} : {4{sd_q[7:0]}};
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign err = done & err_q;
  assign loadData = ld_q;
  assign mem_req = state_q == REQ;
  assign mem_we = mem_req & we_q;
  assign mem_addr = mem_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be = mem_req ? be : '0;
  assign mem_wdata = mem_we ? wdata : '0;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    f3_d = f3_q;
    sd_d = sd_q;
    we_d = we_q;
    err_d = err_q;
    ld_d = ld_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (dMemRead | dMemWrite) begin
        addr_d = addr;
        f3_d = funct3;
        sd_d = storeData;
        we_d = dMemWrite;
        err_d = ~legal;
        cnt_d = '0;
        state_d = legal ? REQ : DONE;
      end
      REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_gnt) begin
          cnt_d = '0;
          state_d = we_q ? DONE : WAIT;
        end else if (tmo) begin
          err_d = 1'b1;
          state_d = DONE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mem_rvalid) begin
          ld_d = ext;
          state_d = DONE;
        end else if (tmo) begin
          err_d = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      f3_q <= '0;
      sd_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      ld_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      f3_q <= f3_d;
      sd_q <= sd_d;
      we_q <= we_d;
      err_q <= err_d;
      ld_q <= ld_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven directed checks plus timeout and mid-access reset sequences.
module tb_load_store_unit;
  logic clk = 1'b0, rst = 1'b0;
  logic dMemRead = 1'b0, dMemWrite = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] addr = '0, storeData = '0;
  logic busy, done, err, mem_req, mem_we;
  logic [31:0] loadData, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] last_load = '0;

  load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst(rst), .dMemRead(dMemRead), .dMemWrite(dMemWrite), .funct3(funct3),
    .addr(addr), .storeData(storeData), .busy(busy), .done(done), .err(err),
    .loadData(loadData), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rdata;
    logic        e;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t t);
    @(negedge clk);
    dMemRead = t.rd; dMemWrite = t.wr; funct3 = t.f3; addr = t.a; storeData = t.sd;
    @(negedge clk);
    dMemRead = 1'b0; dMemWrite = 1'b0;
    if (t.e) begin
      chk({t.name, " done"}, done, 1);
      chk({t.name, " err"}, err, 1);
      chk({t.name, " no_req"}, mem_req, 0);
      chk({t.name, " load_kept"}, loadData, last_load);
    end else begin
      chk({t.name, " req"}, mem_req, 1);
      chk({t.name, " we"}, mem_we, t.wr);
      chk({t.name, " addr"}, mem_addr, t.maddr);
      chk({t.name, " be"}, mem_be, t.be);
      if (t.wr) chk({t.name, " wdata"}, mem_wdata, t.wd);
      chk({t.name, " no_early_done"}, done, 0);
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      if (t.wr) begin
        chk({t.name, " done"}, done, 1);
        chk({t.name, " err"}, err, 0);
      end else begin
        chk({t.name, " wait_no_req"}, {busy, mem_req, done}, 3'b100);
        mem_rvalid = 1'b1; mem_rdata = t.rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk({t.name, " done"}, done, 1);
        chk({t.name, " err"}, err, 0);
        chk({t.name, " loadData"}, loadData, t.ld);
        last_load = t.ld;
      end
    end
  endtask

  vec_t v[15];
  int bad;

  initial begin
    v[0]  = '{"LW",      1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 32'h100, 4'b1111, 0, 32'hDEADBEEF};
    v[1]  = '{"LB",      1, 0, 3'b000, 32'h103, 0, 32'h80112233, 0, 32'h100, 4'b1000, 0, 32'hFFFFFF80};
    v[2]  = '{"LBU",     1, 0, 3'b100, 32'h103, 0, 32'h80112233, 0, 32'h100, 4'b1000, 0, 32'h00000080};
    v[3]  = '{"LHU",     1, 0, 3'b101, 32'h102, 0, 32'h80112233, 0, 32'h100, 4'b1100, 0, 32'h00008011};
    v[4]  = '{"LH",      1, 0, 3'b001, 32'h100, 0, 32'h1234F00D, 0, 32'h100, 4'b0011, 0, 32'hFFFFF00D};
    v[5]  = '{"LB_pos",  1, 0, 3'b000, 32'h101, 0, 32'h00007F00, 0, 32'h100, 4'b0010, 0, 32'h0000007F};
    v[6]  = '{"SB",      0, 1, 3'b000, 32'h201, 32'h000000A5, 0, 0, 32'h200, 4'b0010, 32'hA5A5A5A5, 0};
    v[7]  = '{"SH",      0, 1, 3'b001, 32'h202, 32'h0000BEEF, 0, 0, 32'h200, 4'b1100, 32'hBEEFBEEF, 0};
    v[8]  = '{"SW",      0, 1, 3'b010, 32'h204, 32'h12345678, 0, 0, 32'h204, 4'b1111, 32'h12345678, 0};
    v[9]  = '{"LW_mis",  1, 0, 3'b010, 32'h102, 0, 0, 1, 0, 0, 0, 0};
    v[10] = '{"SH_mis",  0, 1, 3'b001, 32'h101, 0, 0, 1, 0, 0, 0, 0};
    v[11] = '{"LD_f011", 1, 0, 3'b011, 32'h100, 0, 0, 1, 0, 0, 0, 0};
    v[12] = '{"RD_WR",   1, 1, 3'b010, 32'h100, 0, 0, 1, 0, 0, 0, 0};
    v[13] = '{"ST_f100", 0, 1, 3'b100, 32'h200, 0, 0, 1, 0, 0, 0, 0};
    v[14] = '{"LH_f110", 1, 0, 3'b110, 32'h100, 0, 0, 1, 0, 0, 0, 0};
    #2;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst err", err, 0);
    chk("rst req", mem_req, 0);
    chk("rst loadData", loadData, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 15; i++) run(v[i]);
    // Grant withheld: request must stay stable until the timeout aborts it.
    @(negedge clk);
    dMemRead = 1'b1; funct3 = 3'b010; addr = 32'h300;
    @(negedge clk);
    dMemRead = 1'b0;
    bad = 0;
    for (int c = 1; c <= 255; c++) begin
      dMemWrite = c < 10;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300 || mem_be !== 4'hF || mem_we !== 1'b0 || done !== 1'b0) bad++;
      if (c < 255) @(negedge clk);
      else dMemWrite = 1'b0;
    end
    chk("tmo req_stable", bad, 0);
    @(negedge clk);
    chk("tmo done", done, 1);
    chk("tmo err", err, 1);
    chk("tmo req_dropped", mem_req, 0);
    chk("tmo load_kept", loadData, last_load);
    @(negedge clk);
    chk("tmo idle", busy, 0);
    // Reset during WAIT, then a stale rvalid after release.
    @(negedge clk);
    dMemRead = 1'b1; funct3 = 3'b010; addr = 32'h400;
    @(negedge clk);
    dMemRead = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("rstw in_wait", {busy, mem_req}, 2'b10);
    rst = 1'b0;
    #1;
    chk("rstw busy", busy, 0);
    chk("rstw req", mem_req, 0);
    chk("rstw done", done, 0);
    chk("rstw loadData", loadData, 0);
    last_load = '0;
    @(negedge clk);
    rst = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("stale busy", busy, 0);
    chk("stale done", done, 0);
    chk("stale loadData", loadData, 0);
    run('{"LW_after_rst", 1, 0, 3'b010, 32'h404, 0, 32'h0BADF00D, 0, 32'h404, 4'b1111, 0, 32'h0BADF00D});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
